// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: integer register file with two combinational read ports,
// one synchronous write port and a per-register scoreboard of busy bits.
// Optional feature: define RF_BYPASS_EN for write-through bypass on the read
// ports and the busy flags. The default build has no bypass.
module regfile_2r1w_sb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata2,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  busy1,
   output logic                  busy2,
   output logic [ADDR_WIDTH:0]   busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_nxt;
   logic [ADDR_WIDTH:0]   cnt_nxt;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic                  write_ok;
   logic                  issue_ok;

   // Qualify write and issue: dropped while in reset or when aimed at a hardwired x0
   always_comb begin
      write_ok = rst_n && wen && !(ZR && (waddr == '0));
      issue_ok = rst_n && issue_valid && !(ZR && (issue_rd == '0));
   end

   // Next busy vector: clear on writeback, then set on issue so a new producer wins
   always_comb begin
      busy_nxt = busy;
      if (write_ok) busy_nxt[waddr] = 1'b0;
      if (issue_ok) busy_nxt[issue_rd] = 1'b1;
   end

   // Population count of the next busy vector, registered alongside the bits
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_nxt = cnt_nxt + (ADDR_WIDTH + 1)'(busy_nxt[i]);
      end
   end

   // Register storage: all entries cleared by reset so reads never return X
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[waddr] <= wdata;
      end
   end

   // Scoreboard bits and busy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= '0;
         cnt_q <= '0;
      end else begin
         busy  <= busy_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   assign busy_cnt = cnt_q;

   // Read port 1: stored data, zero for hardwired x0, optional write-through
   always_comb begin
      rdata1 = regs[raddr1];
      busy1  = busy[raddr1];
      if (ZR && (raddr1 == '0)) begin
         rdata1 = '0;
         busy1  = 1'b0;
      end
`ifdef RF_BYPASS_EN
      if (write_ok && (waddr == raddr1)) begin
         rdata1 = wdata;
         busy1  = issue_ok && (issue_rd == raddr1);
      end
`endif
   end

   // Read port 2: same structure as port 1
   always_comb begin
      rdata2 = regs[raddr2];
      busy2  = busy[raddr2];
      if (ZR && (raddr2 == '0)) begin
         rdata2 = '0;
         busy2  = 1'b0;
      end
`ifdef RF_BYPASS_EN
      if (write_ok && (waddr == raddr2)) begin
         rdata2 = wdata;
         busy2  = issue_ok && (issue_rd == raddr2);
      end
`endif
   end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: randomized and directed bench for regfile_2r1w_sb with a
// behavioural array model and a per-cycle compare process.
module tb_regfile_2r1w_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int ZR = 1;
   localparam int N  = 2 ** AW;

   logic          clk;
   logic          rst_n;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] raddr1;
   logic [DW-1:0] rdata1;
   logic [AW-1:0] raddr2;
   logic [DW-1:0] rdata2;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          busy1;
   logic          busy2;
   logic [AW:0]   busy_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_regs [N];
   bit            m_busy [N];

   regfile_2r1w_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(ZR)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: array of values and array of busy flags
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_regs[i] <= '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         if (wen && !(ZR != 0 && waddr == 0)) begin
            m_regs[waddr] <= wdata;
            m_busy[waddr] <= 1'b0;
         end
         if (issue_valid && !(ZR != 0 && issue_rd == 0))
            m_busy[issue_rd] <= 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] ra);
      if (ZR != 0 && ra == 0) return '0;
`ifdef RF_BYPASS_EN
      if (rst_n && wen && !(ZR != 0 && waddr == 0) && waddr == ra) return wdata;
`endif
      return m_regs[ra];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] ra);
      if (ZR != 0 && ra == 0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (rst_n && wen && !(ZR != 0 && waddr == 0) && waddr == ra)
         return rst_n && issue_valid && issue_rd == ra;
`endif
      return m_busy[ra];
   endfunction

   function automatic int exp_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   // Compare process: every falling edge, outputs against the model
   always @(negedge clk) begin
      chk("cmp_rdata1", 64'(rdata1), 64'(exp_rdata(raddr1)));
      chk("cmp_rdata2", 64'(rdata2), 64'(exp_rdata(raddr2)));
      chk("cmp_busy1", 64'(busy1), 64'(exp_busy(raddr1)));
      chk("cmp_busy2", 64'(busy2), 64'(exp_busy(raddr2)));
      chk("cmp_busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
   end

   // Drive one cycle of inputs just after the rising edge
   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic iv, input logic [AW-1:0] ir,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      @(posedge clk);
      #1;
      wen = w; waddr = wa; wdata = wd;
      issue_valid = iv; issue_rd = ir;
      raddr1 = r1; raddr2 = r2;
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(1, 0) == 1) return AW'($urandom_range(7, 0));
      return AW'($urandom_range(N - 1, 0));
   endfunction

   initial begin
      logic [DW-1:0] bp_exp;
      rst_n = 1'b0;
      wen = 1'b0; waddr = '0; wdata = '0;
      issue_valid = 1'b0; issue_rd = '0;
      raddr1 = '0; raddr2 = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state on every index, both ports
      for (int i = 0; i < N; i++) begin
         drive(0, 0, 0, 0, 0, AW'(i), AW'(N - 1 - i));
         chk("rst_rdata1", 64'(rdata1), 64'd0);
         chk("rst_rdata2", 64'(rdata2), 64'd0);
         chk("rst_busy1", 64'(busy1), 64'd0);
         chk("rst_busy2", 64'(busy2), 64'd0);
         chk("rst_cnt", 64'(busy_cnt), 64'd0);
      end

      // Write x5, visibility in the write cycle and the next one
`ifdef RF_BYPASS_EN
      bp_exp = 32'hDEADBEEF;
`else
      bp_exp = 32'h0;
`endif
      drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
      chk("x5_same_cycle", 64'(rdata1), 64'(bp_exp));
      drive(0, 0, 0, 0, 0, 5, 0);
      chk("x5_next_cycle", 64'(rdata1), 64'h0000_0000_DEAD_BEEF);

      // Hardwired x0: write and issue both ignored
      drive(1, 0, 32'h12345678, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("x0_rdata", 64'(rdata1), 64'd0);
      chk("x0_busy", 64'(busy1), 64'd0);
      chk("x0_cnt", 64'(busy_cnt), 64'd0);

      // Scoreboard sequence on x3 and x7
      drive(0, 0, 0, 1, 3, 3, 7);
      drive(0, 0, 0, 1, 7, 3, 7);
      chk("sb_cnt1", 64'(busy_cnt), 64'd1);
      chk("sb_busy_x3", 64'(busy1), 64'd1);
      drive(0, 0, 0, 0, 0, 3, 7);
      chk("sb_cnt2", 64'(busy_cnt), 64'd2);
      drive(1, 3, 32'h33, 0, 0, 3, 7);
      drive(0, 0, 0, 0, 0, 3, 7);
      chk("sb_wb_x3_busy", 64'(busy1), 64'd0);
      chk("sb_wb_x3_cnt", 64'(busy_cnt), 64'd1);
      chk("sb_wb_x3_data", 64'(rdata1), 64'h33);
      drive(1, 7, 32'h77, 1, 7, 3, 7);
      drive(0, 0, 0, 0, 0, 3, 7);
      chk("sb_x7_busy", 64'(busy2), 64'd1);
      chk("sb_x7_cnt", 64'(busy_cnt), 64'd1);
      chk("sb_x7_data", 64'(rdata2), 64'h77);
      drive(1, 7, 32'h78, 0, 0, 3, 7);
      drive(0, 0, 0, 0, 0, 3, 7);
      chk("sb_x7_clear", 64'(busy_cnt), 64'd0);

      // Dual read
      drive(1, 10, 32'hCAFE0001, 0, 0, 0, 0);
      drive(1, 11, 32'h00000042, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 10, 10);
      chk("dual_same1", 64'(rdata1), 64'h0000_0000_CAFE_0001);
      chk("dual_same2", 64'(rdata2), 64'h0000_0000_CAFE_0001);
      drive(0, 0, 0, 0, 0, 10, 11);
      chk("dual_diff1", 64'(rdata1), 64'h0000_0000_CAFE_0001);
      chk("dual_diff2", 64'(rdata2), 64'h42);

      // Reset mid-operation: x9 written and busy, then pending ops lost to reset
      drive(1, 9, 32'hA5A5A5A5, 1, 9, 9, 9);
      drive(0, 0, 0, 0, 0, 9, 9);
      chk("mid_pre_data", 64'(rdata1), 64'h0000_0000_A5A5_A5A5);
      chk("mid_pre_busy", 64'(busy1), 64'd1);
      chk("mid_pre_cnt", 64'(busy_cnt), 64'd1);
      wen = 1'b1; waddr = 9; wdata = 32'h11111111;
      issue_valid = 1'b1; issue_rd = 9;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_data", 64'(rdata1), 64'd0);
      chk("mid_rst_busy", 64'(busy1), 64'd0);
      chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_edge_data", 64'(rdata1), 64'd0);
      chk("mid_rst_edge_cnt", 64'(busy_cnt), 64'd0);
      wen = 1'b0; issue_valid = 1'b0;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 9, 10);
      chk("post_rst_x9", 64'(rdata1), 64'd0);
      chk("post_rst_x10", 64'(rdata2), 64'd0);

      // Randomized traffic with occasional reset pulses
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(1, 0)), rnd_addr(), $urandom(),
               1'($urandom_range(1, 0)), rnd_addr(), rnd_addr(), rnd_addr());
         if ($urandom_range(299, 0) == 0) begin
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised integer register file for the NPC core.
- Two combinational read ports and one synchronous write port; entry 0 is optionally hardwired to zero.
- Integrated scoreboard holds one busy bit per register, set when an instruction with a destination issues and cleared when that register is written back.
- Sits between decode (read/issue) and writeback; decode uses the busy flags for stall decisions.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and is never busy; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- wen  in  1  write enable (writeback valid).
- waddr  in  ADDR_WIDTH  write index.
- wdata  in  DATA_WIDTH  write data.
- raddr1  in  ADDR_WIDTH  read port 1 index.
- rdata1  out  DATA_WIDTH  read port 1 data.
- raddr2  in  ADDR_WIDTH  read port 2 index.
- rdata2  out  DATA_WIDTH  read port 2 data.
- issue_valid  in  1  instruction with destination issues this cycle.
- issue_rd  in  ADDR_WIDTH  destination index of issuing instruction.
- busy1  out  1  scoreboard bit of raddr1.
- busy2  out  1  scoreboard bit of raddr2.
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset: rst_n low asynchronously clears all entries to 0, all busy bits to 0 and busy_cnt to 0. While rst_n is low, writes and issues are ignored.
- Reset mid-operation: a pending write or issue in the same cycle as reset assertion is discarded.
- Reads: combinational, zero latency. rdata = entry[raddr].
  - With ZERO_REG=1, raddr==0 returns 0 regardless of stored content.
- Write: on a rising edge with wen=1, entry[waddr] <= wdata.
  - With ZERO_REG=1 and waddr==0, the write is dropped.
  - New data is visible on the read ports from the cycle after the edge, unless RF_BYPASS_EN is defined.
- Scoreboard, per register r, evaluated at each rising edge:
  - set = issue_valid && issue_rd==r.
  - clr = wen && waddr==r.
  - set && !clr: busy[r] <= 1.
  - clr && !set: busy[r] <= 0.
  - set && clr in the same cycle: busy[r] <= 1 (the new producer wins over the retiring one).
  - Neither: hold.
  - With ZERO_REG=1, busy[0] is constant 0 and set/clr to index 0 are ignored.
- Issuing to an already busy register keeps it busy; no error is flagged. A single busy bit per register means the last producer's writeback clears it.
- Writeback to a non-busy register performs the data write; the busy bit stays 0.
- busy1/busy2: combinational, equal to busy[raddr1] and busy[raddr2] as registered (no same-cycle forwarding of set/clr).
- busy_cnt: registered population count of busy bits, updated in the same edge as the busy bits.
  - Range 0 .. 2**ADDR_WIDTH (2**ADDR_WIDTH-1 with ZERO_REG=1).
  - Sizing is ADDR_WIDTH+1 bits, so it never wraps.
- No X propagation: all storage is reset, and reads of never-written entries return 0.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-through bypass.
  - If wen=1 and waddr==raddrN (and not a dropped zero-register write), rdataN = wdata combinationally in that cycle.
  - busyN reads 0 for the same match unless issue_valid && issue_rd==raddrN.
- Not defined: reads return stored content only; a same-cycle write is visible one cycle later and busyN reflects the registered bit.

Test Plan:
- Reset then read all 32 indices on both ports -> every rdata = 0, busy1 = busy2 = 0, busy_cnt = 0.
- Write 0xDEADBEEF to x5 at edge N, read x5 on port 1 -> 0xDEADBEEF from cycle N+1. In cycle N: 0xDEADBEEF with RF_BYPASS_EN defined, 0 without it.
- ZERO_REG=1: write 0x12345678 to x0, issue to x0 -> rdata1(raddr1=0) = 0, busy1 = 0, busy_cnt unchanged.
- Issue x3 and x7 on consecutive cycles -> busy_cnt 1 then 2. Writeback x3 -> busy for x3 = 0, busy_cnt = 1. Simultaneous issue x7 and writeback x7 -> x7 busy stays 1, busy_cnt = 1.
- Issue x9, write x9 = 0xA5A5A5A5, deassert rst_n mid-cycle before the next edge -> immediately rdata(x9) = 0, busy = 0, busy_cnt = 0.
- Dual read: raddr1 = raddr2 = x10 holding 0xCAFE0001 -> both ports return 0xCAFE0001. raddr1 = x10, raddr2 = x11 holding 0x00000042 -> independent correct values.
